console_uart_tx: RTL and testbench
==================================

# console_uart_tx

Memory-mapped console transmitter that sits on the CPU bus alongside the RAM. It captures byte writes to the console data address (0x005A) into a small FIFO and serializes them as 8N1 UART frames on `tx`. It also exposes a read-only status byte at 0x005B. The top level muxes this block's `data_out` over RAM read data whenever `sel` is high.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `DATA_ADDR`, 16'h005A: write address of the transmit data register.
- `STATUS_ADDR`, 16'h005B: address of the status/control register.
- `clock`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `address`  input  16  CPU bus address; full 16-bit decode, no aliasing.
- `write_en`  input  1  CPU write strobe, sampled at the rising edge.
- `data_in`  input  8  CPU write data.
- `data_out`  output  8  combinational read data: status byte when `address==STATUS_ADDR`, else 8'h00.
- `sel`  output  1  combinational; 1 when `address` equals DATA_ADDR or STATUS_ADDR.
- `tx`  output  1  registered serial output; idle high.
- `busy`  output  1  1 when the FIFO is non-empty or a frame is in progress.

## Operation
- Status byte layout:
  - bit0: fifo_full
  - bit1: fifo_empty
  - bit2: tx_active (FSM not IDLE)
  - bit3: overflow (sticky)
  - bits7:4: 0
- **Push:** `write_en=1` with `address==DATA_ADDR` pushes `data_in` when the FIFO is not full. If the FIFO is full, the byte is dropped and overflow is set. Fullness is judged on the pre-edge count, so a push against a full FIFO is dropped even if a pop occurs on the same edge.
- **Overflow clear:** `write_en=1` with `address==STATUS_ADDR` clears overflow; the data value is ignored.
- **Other writes:** writes to any other address are ignored. Reads have no side effects.
- **FIFO:** circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH. Push and pop on the same edge (FIFO not full) leave the count unchanged.
- **TX FSM states:** IDLE, START, DATA, STOP. A bit counter counts 0..7; a baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register, drive `tx=0`, go to START.
  - START: hold `tx=0` for CLKS_PER_BIT cycles, then drive bit0 and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit7, drive `tx=1` and go to STOP.
  - STOP: hold `tx=1` for CLKS_PER_BIT cycles. On the last stop cycle, if the FIFO is non-empty, pop and go directly to START with `tx=0` (no idle gap); otherwise go to IDLE.
- **Reset:** `tx=1`, state IDLE, counters 0, FIFO empty, overflow 0. Therefore `busy=0`, and the status reads 8'h02.
- **Reset mid-frame:** the frame is abandoned and FIFO contents are discarded. `tx` is 1 after the reset edge.

## Timing
- Push captured at edge E. From edge E+1, the status shows not-empty and `busy=1`.
- From IDLE, `tx` falls at edge E+1 (one-cycle latency from push to start bit).
- Frame length is exactly 10·CLKS_PER_BIT cycles, from the `tx` fall to the end of the stop bit.
- Back-to-back frames with a non-empty FIFO have zero idle cycles between the stop bit and the next start bit.
- Pop occurs at the edge the start bit is driven. A FIFO slot therefore frees one frame earlier than completion.
- `busy` falls at the edge leaving STOP with the FIFO empty.
- `data_out` and `sel` follow `address` combinationally. Status bits reflect the registered state.

## Test plan
- **Reset:** assert `reset` 2 cycles with `address=0x005B`. Require `tx=1`, `busy=0`, `sel=1`, `data_out=8'h02`. With `address=0x0010`, require `sel=0` and `data_out=8'h00`.
- **Single byte** (CLKS_PER_BIT=4): write 0x48 to 0x005A.
  - `tx` falls one edge after the write.
  - Sample mid-bit: 0, then 0,0,0,1,0,0,1,0, then 1.
  - `busy` drops exactly 40 cycles after the `tx` fall.
- **Back-to-back** (CLKS_PER_BIT=4): write the 10 bytes "Hellorld!\n" on consecutive cycles.
  - DEPTH=8, so FIFO slots fill and bytes are dropped. Bytes 1..9 are accepted because byte 1 pops at the first start edge; byte 10 ('\n') is dropped and overflow sets, giving status 0x0D.
  - The serial stream decodes to exactly "Hellorld!".
  - Zero-gap frames: 360 cycles total.
- **Overflow clear:** after the overflow test, write 0x5A to 0x005B. Require the next read of 0x005B to show bit3=0. Require no extra `tx` activity.
- **Push/pop same edge at full:** fill the FIFO while IDLE, then time a push onto the pop edge. Require the pushed byte to be dropped, overflow=1, and count = DEPTH-1 afterward.
- **Reset mid-frame:** write 0x55 and 0xAA, then assert `reset` during bit3 of the first frame. Require `tx=1` and `busy=0` after the reset edge, and no further frames.

Source files
------------

// File: rtl/console_uart_tx.sv
// -----------------------------------------------------------------------------
// console_uart_tx
//
// Memory-mapped console transmitter. CPU byte writes to DATA_ADDR are queued
// in a small circular FIFO and sent as 8N1 UART frames on tx, LSB first.
// Frames are sent back to back while the FIFO holds data. STATUS_ADDR reads
// back a status byte. A write to STATUS_ADDR clears the sticky overflow flag.
//
// Ports:
//   clock     system clock, all state changes on the rising edge
//   reset     synchronous, active-high reset
//   address   CPU bus address (full 16-bit decode)
//   write_en  CPU write strobe
//   data_in   CPU write data
//   data_out  combinational read data (status byte at STATUS_ADDR, else 0)
//   sel       combinational, high when address hits DATA_ADDR or STATUS_ADDR
//   tx        registered serial output, idle high
//   busy      high while the FIFO holds data or a frame is in progress
//
// Status byte: {4'b0, overflow, tx_active, fifo_empty, fifo_full}
// -----------------------------------------------------------------------------
module console_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,          // >= 2
   parameter int unsigned FIFO_DEPTH   = 8,           // power of two, >= 2
   parameter logic [15:0] DATA_ADDR    = 16'h005A,
   parameter logic [15:0] STATUS_ADDR  = 16'h005B
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic        write_en,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        sel,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // ---------------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------------
   logic       hit_data;
   logic       hit_status;
   logic       push_req;
   logic       push;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic       tx_active;
   logic [7:0] status;

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;

   assign hit_data   = (address == DATA_ADDR);
   assign hit_status = (address == STATUS_ADDR);
   assign push_req   = write_en && hit_data;
   // Fullness uses the pre-edge count, so a push onto a full FIFO is dropped
   // even when the transmitter pops on the same edge.
   assign push       = push_req && !fifo_full;

   assign fifo_full  = (count_q == CNT_FULL);
   assign fifo_empty = (count_q == '0);
   assign tx_active  = (state_q != IDLE);

   assign status   = {4'b0000, overflow_q, tx_active, fifo_empty, fifo_full};
   assign sel      = hit_data || hit_status;
   assign data_out = hit_status ? status : 8'h00;
   assign tx       = tx_q;
   assign busy     = !fifo_empty || tx_active;

   // ---------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------
   // NOTE: the storage array has no reset; an empty count makes stale entries
   // unreachable, and leaving it out lets the array map onto plain RAM cells.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= data_in;
      end
   end

   // NOTE: every register here is assigned with <= so all flops sample the
   // pre-edge values together, regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (push_req && fifo_full) begin
            overflow_q <= 1'b1;
         end else if (write_en && hit_status) begin
            overflow_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Transmit FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_mem[rd_ptr_q];
               tx_d    = 1'b0;
               baud_d  = '0;
               state_d = START;
            end
         end

         START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // shift_q[0] is the bit on the wire; the next one is [1].
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               // Chain straight into the next start bit to avoid an idle gap.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_mem[rd_ptr_q];
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_console_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_console_uart_tx
//
// Self-checking bench for console_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Directed sequences cover reset, a single frame, back-to-back frames with
// overflow, overflow clear, push at full on the pop edge and reset mid-frame.
// A random phase compares sel/data_out/busy each cycle and the decoded serial
// stream against a transaction-level model of FIFO occupancy and frame timing.
// -----------------------------------------------------------------------------
module tb_console_uart_tx;

   localparam int          CPB    = 4;
   localparam int          DEPTH  = 8;
   localparam int          FRAME  = 10 * CPB;
   localparam logic [15:0] DATA_A = 16'h005A;
   localparam logic [15:0] STAT_A = 16'h005B;

   logic        clock;
   logic        reset;
   logic [15:0] address;
   logic        write_en;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        sel;
   logic        tx;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   console_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .DATA_ADDR    (DATA_A),
      .STATUS_ADDR  (STAT_A)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .address  (address),
      .write_en (write_en),
      .data_in  (data_in),
      .data_out (data_out),
      .sel      (sel),
      .tx       (tx),
      .busy     (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // cyc holds the index of the most recent rising edge.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Serial monitor: finds start bits, samples mid-bit, queues decoded bytes.
   // ---------------------------------------------------------------------------
   byte unsigned rx_q[$];
   int           fall_q[$];
   bit           mon_active = 1'b0;
   int           mon_fall   = 0;
   int           mon_off    = 0;
   logic [7:0]   mon_byte   = '0;

   always @(negedge clock) begin
      if (reset) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && tx === 1'b0) begin
            mon_active = 1'b1;
            mon_fall   = cyc;
            fall_q.push_back(cyc);
         end
         if (mon_active) begin
            mon_off = cyc - mon_fall;
            if (mon_off % CPB == CPB / 2) begin
               if (mon_off / CPB == 0) begin
                  check("mon_start_bit", 32'(tx), 32'(1'b0));
               end else if (mon_off / CPB <= 8) begin
                  mon_byte[mon_off / CPB - 1] = tx;
               end else begin
                  check("mon_stop_bit", 32'(tx), 32'(1'b1));
                  rx_q.push_back(mon_byte);
                  mon_active = 1'b0;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Reference model: FIFO as a queue, transmitter as "busy until edge m_end".
   // ---------------------------------------------------------------------------
   byte unsigned m_fifo[$];
   byte unsigned m_sent[$];
   bit           m_active;
   bit           m_ovf;
   int           m_end;

   function automatic logic [7:0] model_status();
      return {4'b0000, m_ovf, m_active, (m_fifo.size() == 0), (m_fifo.size() == DEPTH)};
   endfunction

   // Advance the model across the next rising edge using the current inputs.
   task automatic model_step();
      int pre;
      int t;
      pre = m_fifo.size();
      t   = cyc + 1;
      if (pre != 0 && (!m_active || t == m_end)) begin
         m_sent.push_back(m_fifo.pop_front());
         m_active = 1'b1;
         m_end    = t + FRAME;
      end else if (m_active && t == m_end) begin
         m_active = 1'b0;
      end
      if (write_en && address == DATA_A) begin
         if (pre == DEPTH) m_ovf = 1'b1;
         else              m_fifo.push_back(data_in);
      end else if (write_en && address == STAT_A) begin
         m_ovf = 1'b0;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Helpers (called just after a falling edge)
   // ---------------------------------------------------------------------------
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      address  = a;
      data_in  = d;
      write_en = 1'b1;
      @(negedge clock);
      write_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(busy), 32'(1'b0));
   endtask

   task automatic read_status(input string name, input logic [7:0] exp);
      address = STAT_A;
      #1;
      check(name, 32'(data_out), 32'(exp));
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [15:0] addr;
      logic        exp_sel;
      logic [7:0]  exp_data;
   } dec_vec_t;

   dec_vec_t dec_tab[7];
   string    hello;
   logic [9:0] frame_bits;
   bit       tx_quiet;
   int       n_before;
   int       r;
   bit       burst;

   initial begin
      dec_tab[0] = '{16'h005A, 1'b1, 8'h00};
      dec_tab[1] = '{16'h005B, 1'b1, 8'h02};
      dec_tab[2] = '{16'h0010, 1'b0, 8'h00};
      dec_tab[3] = '{16'h015B, 1'b0, 8'h00};
      dec_tab[4] = '{16'h805A, 1'b0, 8'h00};
      dec_tab[5] = '{16'h005C, 1'b0, 8'h00};
      dec_tab[6] = '{16'h0000, 1'b0, 8'h00};
      hello = "Hellorld!\n";

      reset    = 1'b1;
      write_en = 1'b0;
      address  = STAT_A;
      data_in  = 8'h00;

      // ---- reset state ----
      repeat (2) @(negedge clock);
      check("reset_tx",     32'(tx),       32'(1'b1));
      check("reset_busy",   32'(busy),     32'(1'b0));
      check("reset_sel",    32'(sel),      32'(1'b1));
      check("reset_status", 32'(data_out), 32'(8'h02));
      reset = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 7; i++) begin
         address = dec_tab[i].addr;
         #1;
         check($sformatf("decode_sel_%04h", dec_tab[i].addr), 32'(sel), 32'(dec_tab[i].exp_sel));
         check($sformatf("decode_data_%04h", dec_tab[i].addr), 32'(data_out), 32'(dec_tab[i].exp_data));
      end
      @(negedge clock);

      // ---- single byte 0x48 ----
      bus_write(DATA_A, 8'h48);
      check("single_tx_at_push_edge", 32'(tx),   32'(1'b1));
      check("single_busy_after_push", 32'(busy), 32'(1'b1));
      @(negedge clock);
      check("single_tx_fall", 32'(tx), 32'(1'b0));
      read_status("single_status_active", 8'h06);
      frame_bits = {1'b1, 8'h48, 1'b0};
      for (int k = 0; k < 10; k++) begin
         repeat (2) @(negedge clock);
         check($sformatf("single_bit%0d", k), 32'(tx), 32'(frame_bits[k]));
         if (k < 9) repeat (2) @(negedge clock);
      end
      @(negedge clock);
      check("single_busy_cycle39", 32'(busy), 32'(1'b1));
      @(negedge clock);
      check("single_busy_cycle40", 32'(busy), 32'(1'b0));
      check("single_tx_idle",      32'(tx),   32'(1'b1));

      // ---- back-to-back "Hellorld!\n" with overflow ----
      repeat (3) @(negedge clock);
      rx_q.delete();
      fall_q.delete();
      for (int i = 0; i < 10; i++) bus_write(DATA_A, hello[i]);
      read_status("b2b_status_overflow", 8'h0D);
      wait_idle("b2b_drain", 600);
      check("b2b_frame_count", 32'(fall_q.size()), 32'(9));
      if (fall_q.size() > 0) check("b2b_total_cycles", 32'(cyc - fall_q[0]), 32'(9 * FRAME));
      for (int i = 1; i < fall_q.size(); i++)
         check($sformatf("b2b_gap%0d", i), 32'(fall_q[i] - fall_q[i-1]), 32'(FRAME));
      check("b2b_rx_count", 32'(rx_q.size()), 32'(9));
      for (int i = 0; i < rx_q.size() && i < 9; i++)
         check($sformatf("b2b_rx%0d", i), 32'(rx_q[i]), 32'(hello[i]));

      // ---- overflow clear ----
      read_status("ovf_status_before", 8'h0A);
      @(negedge clock);
      n_before = fall_q.size();
      bus_write(STAT_A, 8'h5A);
      read_status("ovf_status_cleared", 8'h02);
      tx_quiet = 1'b1;
      repeat (60) begin
         @(negedge clock);
         if (tx !== 1'b1) tx_quiet = 1'b0;
      end
      check("ovf_clear_tx_quiet", 32'(tx_quiet),       32'(1'b1));
      check("ovf_clear_no_frame", 32'(fall_q.size()), 32'(n_before));

      // ---- push onto the pop edge while full ----
      rx_q.delete();
      fall_q.delete();
      for (int i = 0; i < 9; i++) bus_write(DATA_A, 8'h30 + 8'(i));
      // First pop two edges after the first write; next pop one frame later.
      repeat (32) @(negedge clock);
      read_status("full_status_before", 8'h05);
      bus_write(DATA_A, 8'hEE);
      read_status("full_status_after", 8'h0C);
      wait_idle("full_drain", 600);
      check("full_rx_count", 32'(rx_q.size()), 32'(9));
      for (int i = 0; i < rx_q.size() && i < 9; i++)
         check($sformatf("full_rx%0d", i), 32'(rx_q[i]), 32'(8'h30 + 8'(i)));
      read_status("full_status_idle", 8'h0A);

      // ---- reset mid-frame ----
      @(negedge clock);
      bus_write(DATA_A, 8'h55);
      bus_write(DATA_A, 8'hAA);
      repeat (16) @(negedge clock);
      check("rst_mid_bit3", 32'(tx), 32'(1'b0));
      reset = 1'b1;
      @(negedge clock);
      check("rst_mid_tx",   32'(tx),   32'(1'b1));
      check("rst_mid_busy", 32'(busy), 32'(1'b0));
      read_status("rst_mid_status", 8'h02);
      @(negedge clock);
      reset = 1'b0;
      rx_q.delete();
      fall_q.delete();
      tx_quiet = 1'b1;
      repeat (100) begin
         @(negedge clock);
         if (tx !== 1'b1) tx_quiet = 1'b0;
      end
      check("rst_mid_tx_quiet", 32'(tx_quiet),       32'(1'b1));
      check("rst_mid_no_frame", 32'(fall_q.size()), 32'(0));

      // ---- randomized traffic against the model ----
      do_reset();
      rx_q.delete();
      fall_q.delete();
      m_fifo.delete();
      m_sent.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
      m_end    = 0;
      for (int i = 0; i < 2000; i++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 3)      address = DATA_A;
         else if (r <= 5) address = STAT_A;
         else if (r == 6) address = 16'($urandom);
         else             address = 16'h0040 + 16'(r);
         burst   = ((i / 150) % 2 == 0);
         data_in = 8'($urandom);
         if (i >= 1500)  write_en = 1'b0;
         else if (burst) write_en = ($urandom_range(0, 3) == 0);
         else            write_en = ($urandom_range(0, 39) == 0);
         #1;
         check("rand_sel", 32'(sel),
               32'((address == DATA_A) || (address == STAT_A)));
         check("rand_data_out", 32'(data_out),
               32'((address == STAT_A) ? model_status() : 8'h00));
         check("rand_busy", 32'(busy), 32'((m_fifo.size() != 0) || m_active));
         model_step();
         @(negedge clock);
      end
      write_en = 1'b0;
      check("rand_final_idle", 32'(busy), 32'(1'b0));
      check("rand_rx_count", 32'(rx_q.size()), 32'(m_sent.size()));
      for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
         check($sformatf("rand_rx%0d", i), 32'(rx_q[i]), 32'(m_sent[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
